encoder4_2_event: RTL

- Sequential 4-to-2 event encoder; the inverse of the team's 2-to-4 decoder.
- Captures rising edges on four one-hot-style request lines and queues them as pending events.
- Emits each event as a 2-bit binary index over a valid/ready handshake.
- Sits between raw event/interrupt lines and a consumer that reads one encoded index at a time.

---
 rtl/encoder4_2_event.sv | 133 +++++++++++++
 1 files changed

// File: rtl/encoder4_2_event.sv
// rtl/encoder4_2_event.sv - 4-to-2 event encoder: edge capture, pending queue, valid/ready index output
// Optional: define ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index priority.
module encoder4_2_event #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_IN-1:0] D,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic              out_valid,
  output logic [IDX_W-1:0]  Y,
  output logic [NUM_IN-1:0] pending,
  output logic              overflow
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t            r_state;
  logic [NUM_IN-1:0] r_d_prev;
  logic [NUM_IN-1:0] r_pending;
  logic              r_ovf;
  logic [IDX_W-1:0]  r_y;

  logic [NUM_IN-1:0] w_rise;
  logic [NUM_IN-1:0] w_grant;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_sel_found;
  logic              w_load;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  w_cand;
`endif

  // d_prev follows D even when disabled, so re-enabling with D high does not look like a rise
  assign w_rise = D & ~r_d_prev & {NUM_IN{enable}};

  // Pick the next pending index; only registered pending is considered
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
`ifdef ROUND_ROBIN_EN
    w_cand      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_cand = r_ptr + IDX_W'(k);
      if (!w_sel_found && r_pending[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
`else
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(k);
      end
    end
`endif
  end

  // Load happens when the output slot is free or being freed this cycle
  assign w_load = w_sel_found && ((r_state == ST_EMPTY) || out_ready);

  // One-hot grant of the loaded index
  always_comb begin
    w_grant            = '0;
    w_grant[w_sel_idx] = w_load;
  end

  // Edge history, pending set/clear (rise beats grant) and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_prev  <= '0;
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_d_prev  <= D;
      r_pending <= (r_pending & ~w_grant) | w_rise;
      if (|(w_rise & r_pending & ~w_grant)) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Output slot: EMPTY loads when something is pending, FULL holds until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_y     <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            r_state <= ST_FULL;
            r_y     <= w_sel_idx;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (w_load) begin
              r_y <= w_sel_idx;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef ROUND_ROBIN_EN
  // Search start moves to the index after the last one loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_load) begin
      r_ptr <= w_sel_idx + IDX_W'(1);
    end
  end
`endif

  assign out_valid = (r_state == ST_FULL);
  assign Y         = r_y;
  assign pending   = r_pending;
  assign overflow  = r_ovf;

endmodule
